// File: rtl/imm_gen_if.sv
// Handshake bundle between the decode stage and the immediate generator.
// The master side feeds instructions and takes results.
// The slave side is the generator itself.
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate generator at the ID->EX boundary.
// The immediate format is decoded from the instruction opcode.
// A valid/ready output register holds the result. An optional skid entry
// absorbs EX back-pressure, so in_ready does not depend combinationally
// on out_ready.
module imm_gen_stage #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 32,
    parameter bit SKID_EN    = 1'b1,
    parameter bit SLTIU_ZEXT = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    imm_gen_if.slave  bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] FMT_I     = 3'd0;
    localparam logic [2:0] FMT_IZ    = 3'd1;
    localparam logic [2:0] FMT_SHAMT = 3'd2;
    localparam logic [2:0] FMT_S     = 3'd3;
    localparam logic [2:0] FMT_B     = 3'd4;
    localparam logic [2:0] FMT_U     = 3'd5;
    localparam logic [2:0] FMT_J     = 3'd6;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    // Decode results
    logic [31:0]      raw_s;       // immediate already correctly extended to 32 bits
    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_fmt_s;
    logic             dec_ill_s;

    // Main output register
    logic             out_valid_r;
    logic [XLEN-1:0]  out_imm_r;
    logic [2:0]       out_fmt_r;
    logic             out_ill_r;
    logic [TAG_W-1:0] out_tag_r;

    // Skid entry
    logic             skid_valid_r;
    logic [XLEN-1:0]  skid_imm_r;
    logic [2:0]       skid_fmt_r;
    logic             skid_ill_r;
    logic [TAG_W-1:0] skid_tag_r;

    logic             in_ready_r;
    logic             in_ready_s;
    logic             accept_s;
    logic             main_free_s;

    // Decode the immediate and its format from the raw instruction.
    // Every format is built as a 32-bit value whose top bit is the extension bit.
    // Zero-extended formats therefore widen correctly through a signed cast.
    always_comb begin
        raw_s     = 32'd0;
        dec_fmt_s = FMT_NONE;
        dec_ill_s = 1'b0;
        case (bus.in_inst[6:0])
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec_fmt_s = FMT_I;
                raw_s     = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
            end
            OP_IMM: begin
                if ((bus.in_inst[14:12] == 3'b001) || (bus.in_inst[14:12] == 3'b101)) begin
                    dec_fmt_s = FMT_SHAMT;
                    if (XLEN == 64) begin
                        raw_s = {26'd0, bus.in_inst[25:20]};
                    end else begin
                        raw_s = {27'd0, bus.in_inst[24:20]};
                    end
                end else if ((bus.in_inst[14:12] == 3'b011) && SLTIU_ZEXT) begin
                    dec_fmt_s = FMT_IZ;
                    raw_s     = {20'd0, bus.in_inst[31:20]};
                end else begin
                    dec_fmt_s = FMT_I;
                    raw_s     = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
                end
            end
            OP_STORE: begin
                dec_fmt_s = FMT_S;
                raw_s     = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt_s = FMT_B;
                raw_s     = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                             bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt_s = FMT_U;
                raw_s     = {bus.in_inst[31:12], 12'd0};
            end
            OP_JAL: begin
                dec_fmt_s = FMT_J;
                raw_s     = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                             bus.in_inst[20], bus.in_inst[30:21], 1'b0};
            end
            OP_OP, OP_FENCE: begin
                dec_fmt_s = FMT_NONE;
                raw_s     = 32'd0;
            end
            default: begin
                dec_fmt_s = FMT_NONE;
                dec_ill_s = 1'b1;
                raw_s     = 32'd0;
            end
        endcase
        dec_imm_s = XLEN'(signed'(raw_s));
    end

    // Handshake qualifiers.
    // With a skid entry, in_ready comes from a register.
    // Without one, in_ready is allowed to look at out_ready.
    always_comb begin
        if (SKID_EN) begin
            in_ready_s = in_ready_r;
        end else begin
            in_ready_s = bus.out_ready || !out_valid_r;
        end
        accept_s    = bus.in_valid && in_ready_s;
        main_free_s = !out_valid_r || bus.out_ready;
    end

    // Pipeline register plus skid entry.
    // A flush squashes everything, including a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_imm_r    <= '0;
            out_fmt_r    <= FMT_NONE;
            out_ill_r    <= 1'b0;
            out_tag_r    <= '0;
            skid_valid_r <= 1'b0;
            skid_imm_r   <= '0;
            skid_fmt_r   <= FMT_NONE;
            skid_ill_r   <= 1'b0;
            skid_tag_r   <= '0;
            in_ready_r   <= 1'b1;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (SKID_EN) begin
            if (main_free_s && skid_valid_r) begin
                // The older entry waiting in skid takes priority.
                out_valid_r  <= 1'b1;
                out_imm_r    <= skid_imm_r;
                out_fmt_r    <= skid_fmt_r;
                out_ill_r    <= skid_ill_r;
                out_tag_r    <= skid_tag_r;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end else if (main_free_s && accept_s) begin
                out_valid_r  <= 1'b1;
                out_imm_r    <= dec_imm_s;
                out_fmt_r    <= dec_fmt_s;
                out_ill_r    <= dec_ill_s;
                out_tag_r    <= bus.in_tag;
                in_ready_r   <= 1'b1;
            end else if (accept_s) begin
                // Main is full and stalled, so park the new entry in skid.
                skid_valid_r <= 1'b1;
                skid_imm_r   <= dec_imm_s;
                skid_fmt_r   <= dec_fmt_s;
                skid_ill_r   <= dec_ill_s;
                skid_tag_r   <= bus.in_tag;
                in_ready_r   <= 1'b0;
            end else begin
                out_valid_r  <= out_valid_r && !bus.out_ready;
                in_ready_r   <= !skid_valid_r;
            end
        end else begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_imm_r   <= dec_imm_s;
                out_fmt_r   <= dec_fmt_s;
                out_ill_r   <= dec_ill_s;
                out_tag_r   <= bus.in_tag;
            end else begin
                out_valid_r <= out_valid_r && !bus.out_ready;
            end
            in_ready_r <= 1'b1;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_imm     = out_imm_r;
    assign bus.out_fmt     = out_fmt_r;
    assign bus.out_illegal = out_ill_r;
    assign bus.out_tag     = out_tag_r;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage.
// Instance A: XLEN=32, with skid entry, SLTIU zero-extended.
// Instance B: XLEN=64, no skid entry, SLTIU sign-extended.
module tb_imm_gen_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    imm_gen_if #(.XLEN(32), .TAG_W(32)) ia ();
    imm_gen_if #(.XLEN(64), .TAG_W(32)) ib ();

    imm_gen_stage #(.XLEN(32), .TAG_W(32), .SKID_EN(1'b1), .SLTIU_ZEXT(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (ia)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32), .SKID_EN(1'b0), .SLTIU_ZEXT(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (ib)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t va [11];
    vec_t vb [5];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] inst, input logic [31:0] tag);
        ia.in_valid = 1'b1;
        ia.in_inst  = inst;
        ia.in_tag   = tag;
        step();
        ia.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] inst, input logic [31:0] tag);
        ib.in_valid = 1'b1;
        ib.in_inst  = inst;
        ib.in_tag   = tag;
        step();
        ib.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        va[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 3'd0, 1'b0};  // addi -1
        va[1]  = '{32'hFFF03093, 64'h00000FFF, 3'd1, 1'b0};  // sltiu zext
        va[2]  = '{32'hFE000EE3, 64'hFFFFFFFC, 3'd4, 1'b0};  // beq -4
        va[3]  = '{32'h12345037, 64'h12345000, 3'd5, 1'b0};  // lui
        va[4]  = '{32'h0080006F, 64'h00000008, 3'd6, 1'b0};  // jal +8
        va[5]  = '{32'hFFFFFFFF, 64'h00000000, 3'd7, 1'b1};  // illegal
        va[6]  = '{32'h00B50533, 64'h00000000, 3'd7, 1'b0};  // add
        va[7]  = '{32'hFE112E23, 64'hFFFFFFFC, 3'd3, 1'b0};  // sw -4
        va[8]  = '{32'h00412083, 64'h00000004, 3'd0, 1'b0};  // lw +4
        va[9]  = '{32'h40515093, 64'h00000005, 3'd2, 1'b0};  // srai 5
        va[10] = '{32'h03F09093, 64'h0000001F, 3'd2, 1'b0};  // slli, 5-bit shamt at XLEN 32

        vb[0]  = '{32'h03F09093, 64'h000000000000003F, 3'd2, 1'b0};
        vb[1]  = '{32'hFFF03093, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
        vb[2]  = '{32'h80000037, 64'hFFFFFFFF80000000, 3'd5, 1'b0};
        vb[3]  = '{32'h12345037, 64'h0000000012345000, 3'd5, 1'b0};
        vb[4]  = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0};

        ia.in_valid = 1'b0; ia.in_inst = 32'd0; ia.in_tag = 32'd0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_inst = 32'd0; ib.in_tag = 32'd0; ib.out_ready = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_valid", 64'(ia.out_valid), 64'd0);
        check_val("rst_ready", 64'(ia.in_ready), 64'd1);
        check_val("rst_imm", 64'(ia.out_imm), 64'd0);
        check_val("rst_fmt", 64'(ia.out_fmt), 64'd7);
        check_val("rst_ill", 64'(ia.out_illegal), 64'd0);
        check_val("rst_tag", 64'(ia.out_tag), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Decode table through instance A at full rate
        ia.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send_a(va[i].inst, 32'h100 + 32'(i));
            check_val($sformatf("a%0d_valid", i), 64'(ia.out_valid), 64'd1);
            check_val($sformatf("a%0d_imm", i), 64'(ia.out_imm), va[i].imm);
            check_val($sformatf("a%0d_fmt", i), 64'(ia.out_fmt), 64'(va[i].fmt));
            check_val($sformatf("a%0d_ill", i), 64'(ia.out_illegal), 64'(va[i].ill));
            check_val($sformatf("a%0d_tag", i), 64'(ia.out_tag), 64'h100 + 64'(i));
            check_val($sformatf("a%0d_rdy", i), 64'(ia.in_ready), 64'd1);
        end
        step();
        check_val("hold_valid", 64'(ia.out_valid), 64'd0);
        check_val("hold_imm", 64'(ia.out_imm), 64'h1F);
        check_val("hold_fmt", 64'(ia.out_fmt), 64'd2);

        // Skid: three back-to-back inputs while stalled
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1; ia.in_inst = 32'h12345037; ia.in_tag = 32'h10;
        check_val("t4_rdy_a", 64'(ia.in_ready), 64'd1);
        step();
        ia.in_inst = 32'h0080006F; ia.in_tag = 32'h11;
        check_val("t4_rdy_b", 64'(ia.in_ready), 64'd1);
        step();
        check_val("t4_full", 64'(ia.in_ready), 64'd0);
        ia.in_inst = 32'hFE000EE3; ia.in_tag = 32'h12;
        step();
        check_val("t4_stall_rdy", 64'(ia.in_ready), 64'd0);
        check_val("t4_stall_valid", 64'(ia.out_valid), 64'd1);
        check_val("t4_stall_tag", 64'(ia.out_tag), 64'h10);
        check_val("t4_stall_imm", 64'(ia.out_imm), 64'h12345000);
        ia.out_ready = 1'b1;
        step();
        check_val("t4_b_valid", 64'(ia.out_valid), 64'd1);
        check_val("t4_b_tag", 64'(ia.out_tag), 64'h11);
        check_val("t4_b_imm", 64'(ia.out_imm), 64'h8);
        check_val("t4_b_rdy", 64'(ia.in_ready), 64'd1);
        step();
        ia.in_valid = 1'b0;
        check_val("t4_c_valid", 64'(ia.out_valid), 64'd1);
        check_val("t4_c_tag", 64'(ia.out_tag), 64'h12);
        check_val("t4_c_imm", 64'(ia.out_imm), 64'hFFFFFFFC);
        step();
        check_val("t4_empty", 64'(ia.out_valid), 64'd0);

        // Flush while two entries are held and an input is offered
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1; ia.in_inst = 32'hFFF00093; ia.in_tag = 32'h20;
        step();
        ia.in_tag = 32'h21;
        step();
        check_val("t5_full", 64'(ia.in_ready), 64'd0);
        ia.in_tag = 32'h22;
        flush = 1'b1;
        step();
        flush = 1'b0;
        ia.in_valid = 1'b0;
        check_val("t5_valid", 64'(ia.out_valid), 64'd0);
        check_val("t5_rdy", 64'(ia.in_ready), 64'd1);
        ia.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("t5_ghost%0d", i), 64'(ia.out_valid), 64'd0);
        end
        // Flush beats a same-cycle accept into an empty stage
        ia.in_valid = 1'b1; ia.in_tag = 32'h23;
        flush = 1'b1;
        step();
        flush = 1'b0;
        ia.in_valid = 1'b0;
        check_val("t5_prio", 64'(ia.out_valid), 64'd0);
        send_a(32'h00412083, 32'h24);
        check_val("t5_fresh_tag", 64'(ia.out_tag), 64'h24);
        check_val("t5_fresh_imm", 64'(ia.out_imm), 64'h4);
        step();

        // Asynchronous reset in the middle of a stall
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1; ia.in_inst = 32'h12345037; ia.in_tag = 32'h30;
        step();
        ia.in_tag = 32'h31;
        step();
        ia.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_val("t6_valid", 64'(ia.out_valid), 64'd0);
        check_val("t6_rdy", 64'(ia.in_ready), 64'd1);
        step();
        rst_n = 1'b1;
        ia.out_ready = 1'b1;
        send_a(32'hFFF00093, 32'h32);
        check_val("t6_fresh_valid", 64'(ia.out_valid), 64'd1);
        check_val("t6_fresh_tag", 64'(ia.out_tag), 64'h32);
        step();
        check_val("t6_drained", 64'(ia.out_valid), 64'd0);

        // Instance B: XLEN=64 decode
        ib.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_b(vb[i].inst, 32'h40 + 32'(i));
            check_val($sformatf("b%0d_valid", i), 64'(ib.out_valid), 64'd1);
            check_val($sformatf("b%0d_imm", i), ib.out_imm, vb[i].imm);
            check_val($sformatf("b%0d_fmt", i), 64'(ib.out_fmt), 64'(vb[i].fmt));
            check_val($sformatf("b%0d_tag", i), 64'(ib.out_tag), 64'h40 + 64'(i));
        end
        step();

        // Instance B: single register, back-pressure then accept-and-drain
        ib.out_ready = 1'b0;
        ib.in_valid  = 1'b1; ib.in_inst = 32'h12345037; ib.in_tag = 32'h50;
        step();
        check_val("b_bp_valid", 64'(ib.out_valid), 64'd1);
        check_val("b_bp_rdy", 64'(ib.in_ready), 64'd0);
        ib.in_inst = 32'h0080006F; ib.in_tag = 32'h51;
        step();
        check_val("b_bp_hold", 64'(ib.out_tag), 64'h50);
        ib.out_ready = 1'b1;
        #1;
        check_val("b_comb_rdy", 64'(ib.in_ready), 64'd1);
        step();
        ib.in_valid = 1'b0;
        check_val("b_next_valid", 64'(ib.out_valid), 64'd1);
        check_val("b_next_tag", 64'(ib.out_tag), 64'h51);
        check_val("b_next_imm", ib.out_imm, 64'h8);
        step();
        check_val("b_empty", 64'(ib.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
